hazard_bubble_ctrl: RTL and testbench

Parametrised hazard controller that owns the ID/EX control register of the pipelined RISC-V core. It detects load-use hazards, holds the pipeline for multi-cycle EX operations, and squashes on branch/jump redirect. On a hazard it inserts an all-zero control bubble into EX. It sits between the decoder (ID) and the EX stage, and drives the PC and IF/ID write/flush enables.

---
 rtl/hazard_bubble_ctrl_pkg.sv | 31 +++
 rtl/hazard_bubble_ctrl_if.sv | 38 +++
 rtl/hazard_lu_detect.sv | 27 ++
 rtl/hazard_bubble_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_bubble_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_bubble_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_bubble_ctrl_pkg
// Brief    : Shared control-bundle bit map, widths and FSM encoding.
// Revision : 1.0
// ============================================================================
package hazard_bubble_ctrl_pkg;

    localparam int CTRL_W = 11;
    localparam int REG_W  = 5;

    // Control bundle bit map, MSB first: BRANCH .. ALUOP[1:0]
    localparam int IDX_ALUOP_LO = 0;
    localparam int IDX_ALUOP_HI = 1;
    localparam int IDX_PCSEL    = 2;
    localparam int IDX_RETURN   = 3;
    localparam int IDX_REGWRITE = 4;
    localparam int IDX_ALUSRC   = 5;
    localparam int IDX_MEMWRITE = 6;
    localparam int IDX_MEMTOREG = 7;
    localparam int IDX_MEMREAD  = 8;
    localparam int IDX_JUMP     = 9;
    localparam int IDX_BRANCH   = 10;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_bubble_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_bubble_ctrl_if
// Brief    : ID-side inputs and ID/EX / fetch-control outputs of the hazard unit.
// Revision : 1.0
// ============================================================================
interface hazard_bubble_ctrl_if #(
    parameter int CTRL_W = hazard_bubble_ctrl_pkg::CTRL_W,
    parameter int REG_W  = hazard_bubble_ctrl_pkg::REG_W,
    parameter int BCNT_W = 16
);
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_W-1:0]  id_rd;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_mc;
    logic              ex_redirect;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_W-1:0]  ex_rd;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              mc_busy;
    logic [BCNT_W-1:0] bubble_cnt;

    modport master (
        output id_ctrl, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_mc, ex_redirect,
        input  ex_ctrl, ex_rd, pc_write, ifid_write, ifid_flush, mc_busy, bubble_cnt
    );

    modport slave (
        input  id_ctrl, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_mc, ex_redirect,
        output ex_ctrl, ex_rd, pc_write, ifid_write, ifid_flush, mc_busy, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_lu_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_lu_detect
// Brief    : Combinational load-use compare between the EX load and ID sources.
// Revision : 1.0
// ============================================================================
module hazard_lu_detect #(
    parameter int REG_W = hazard_bubble_ctrl_pkg::REG_W
) (
    input  wire             ex_memread,
    input  wire [REG_W-1:0] ex_rd,
    input  wire [REG_W-1:0] id_rs1,
    input  wire [REG_W-1:0] id_rs2,
    input  wire             id_use_rs1,
    input  wire             id_use_rs2,
    output logic            lu
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 never carries a forwarded load value, so it cannot create a hazard
    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu        = ex_memread && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_bubble_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_bubble_ctrl
// Brief    : ID/EX control register owner: load-use stall, multi-cycle hold,
//            redirect squash and saturating bubble counter.
// Revision : 1.0
// ============================================================================
module hazard_bubble_ctrl #(
    parameter int CTRL_W      = hazard_bubble_ctrl_pkg::CTRL_W,
    parameter int MEMREAD_IDX = hazard_bubble_ctrl_pkg::IDX_MEMREAD,
    parameter int REG_W       = hazard_bubble_ctrl_pkg::REG_W,
    parameter int MC_LAT      = 4,
    parameter int BCNT_W      = 16
) (
    input wire clk,
    input wire reset,
    hazard_bubble_ctrl_if.slave bus
);
    import hazard_bubble_ctrl_pkg::*;

    localparam int CNT_W = $clog2(MC_LAT);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [REG_W-1:0]  r_ex_rd;
    logic [BCNT_W-1:0] r_bcnt;

    logic w_lu;
    logic w_bubble;
    logic w_issue;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_mc_busy;

    hazard_lu_detect #(
        .REG_W (REG_W)
    ) u_lu_detect (
        .ex_memread (r_ex_ctrl[MEMREAD_IDX]),
        .ex_rd      (r_ex_rd),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .lu         (w_lu)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bubble     = 1'b0;
        w_issue      = 1'b0;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_mc_busy    = 1'b0;
        // Reset pins the fetch controls to free-running regardless of ID/EX inputs
        if (reset) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end else if (bus.ex_redirect) begin
            w_ifid_flush = 1'b1;
            w_bubble     = 1'b1;
            w_state_nxt  = ST_RUN;
            w_cnt_nxt    = '0;
        end else if (r_state == ST_MC_WAIT) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_mc_busy    = 1'b1;
            w_cnt_nxt    = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_lu) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
        end else begin
            w_issue = 1'b1;
            // The issue cycle is the first EX cycle, so MC_LAT-1 cycles remain
            if (bus.id_mc) begin
                w_state_nxt = ST_MC_WAIT;
                w_cnt_nxt   = CNT_W'(MC_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ctrl <= '0;
            r_ex_rd   <= '0;
        end else if (w_bubble) begin
            r_ex_ctrl <= '0;
            r_ex_rd   <= '0;
        end else if (w_issue) begin
            r_ex_ctrl <= bus.id_ctrl;
            r_ex_rd   <= bus.id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcnt <= '0;
        end else if (w_bubble && (r_bcnt != '1)) begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    assign bus.ex_ctrl    = r_ex_ctrl;
    assign bus.ex_rd      = r_ex_rd;
    assign bus.pc_write   = w_pc_write;
    assign bus.ifid_write = w_ifid_write;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.mc_busy    = w_mc_busy;
    assign bus.bubble_cnt = r_bcnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_bubble_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_bubble_ctrl
// Brief    : Directed + random bench for hazard_bubble_ctrl (default and 3-bit counter).
// Revision : 1.0
// ============================================================================
module tb_hazard_bubble_ctrl;
    import hazard_bubble_ctrl_pkg::*;

    localparam int MC_LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_bubble_ctrl_if bus ();
    hazard_bubble_ctrl_if #(.BCNT_W(3)) bus_s ();

    assign bus_s.id_ctrl     = bus.id_ctrl;
    assign bus_s.id_rd       = bus.id_rd;
    assign bus_s.id_rs1      = bus.id_rs1;
    assign bus_s.id_rs2      = bus.id_rs2;
    assign bus_s.id_use_rs1  = bus.id_use_rs1;
    assign bus_s.id_use_rs2  = bus.id_use_rs2;
    assign bus_s.id_mc       = bus.id_mc;
    assign bus_s.ex_redirect = bus.ex_redirect;

    hazard_bubble_ctrl #(.MC_LAT(MC_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    hazard_bubble_ctrl #(.MC_LAT(MC_LAT), .BCNT_W(3)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what EX holds, how many hold cycles remain, total bubbles
    logic [CTRL_W-1:0] m_ex_ctrl;
    logic [REG_W-1:0]  m_ex_rd;
    int                m_stall;
    int                m_bub;

    logic [CTRL_W-1:0] lw_c;
    logic [CTRL_W-1:0] add_c;
    logic [CTRL_W-1:0] mul_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int satv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_ex_ctrl = '0;
        m_ex_rd   = '0;
        m_stall   = 0;
        m_bub     = 0;
    endtask

    task automatic drive(input logic [CTRL_W-1:0] c, input logic [REG_W-1:0] rd,
                         input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                         input logic u1, input logic u2, input logic mc, input logic redir);
        bus.id_ctrl     = c;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.id_mc       = mc;
        bus.ex_redirect = redir;
    endtask

    task automatic drive_rand();
        logic [CTRL_W-1:0] c;
        c = CTRL_W'($urandom);
        c[IDX_MEMREAD] = ($urandom_range(0, 1) == 1);
        drive(c, REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
              REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    endtask

    // One clock: check fetch controls mid-cycle, advance the model, check EX after the edge
    task automatic cycle();
        logic lu, e_pc, e_ifw, e_fl, e_busy;
        if (clk) @(negedge clk);
        #1;
        lu = m_ex_ctrl[IDX_MEMREAD] && (m_ex_rd != '0) &&
             ((bus.id_use_rs1 && (bus.id_rs1 == m_ex_rd)) ||
              (bus.id_use_rs2 && (bus.id_rs2 == m_ex_rd)));
        e_pc = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; e_busy = 1'b0;
        if (bus.ex_redirect) begin
            e_fl = 1'b1;
            m_ex_ctrl = '0; m_ex_rd = '0; m_stall = 0; m_bub++;
        end else if (m_stall > 0) begin
            e_pc = 1'b0; e_ifw = 1'b0; e_busy = 1'b1;
            m_stall--;
        end else if (lu) begin
            e_pc = 1'b0; e_ifw = 1'b0;
            m_ex_ctrl = '0; m_ex_rd = '0; m_bub++;
        end else begin
            m_ex_ctrl = bus.id_ctrl;
            m_ex_rd   = bus.id_rd;
            if (bus.id_mc) m_stall = MC_LAT - 1;
        end
        chk("pc_write",   32'(bus.pc_write),   32'(e_pc));
        chk("ifid_write", 32'(bus.ifid_write), 32'(e_ifw));
        chk("ifid_flush", 32'(bus.ifid_flush), 32'(e_fl));
        chk("mc_busy",    32'(bus.mc_busy),    32'(e_busy));
        @(posedge clk);
        #1;
        chk("ex_ctrl",      32'(bus.ex_ctrl),      32'(m_ex_ctrl));
        chk("ex_rd",        32'(bus.ex_rd),        32'(m_ex_rd));
        chk("bubble_cnt",   32'(bus.bubble_cnt),   32'(satv(m_bub, 65535)));
        chk("bubble_cnt3",  32'(bus_s.bubble_cnt), 32'(satv(m_bub, 7)));
        chk("ex_ctrl_sat",  32'(bus_s.ex_ctrl),    32'(m_ex_ctrl));
    endtask

    initial begin
        lw_c  = '0; lw_c[IDX_MEMREAD] = 1'b1; lw_c[IDX_MEMTOREG] = 1'b1;
        lw_c[IDX_REGWRITE] = 1'b1; lw_c[IDX_ALUSRC] = 1'b1;
        add_c = '0; add_c[IDX_REGWRITE] = 1'b1; add_c[IDX_ALUOP_HI] = 1'b1;
        mul_c = add_c; mul_c[IDX_ALUOP_LO] = 1'b1;

        // Reset with a redirect pending: flush must stay low while in reset
        reset = 1'b1;
        drive(lw_c, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ctrl",    32'(bus.ex_ctrl),    32'd0);
        chk("rst_ex_rd",      32'(bus.ex_rd),      32'd0);
        chk("rst_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("rst_pc_write",   32'(bus.pc_write),   32'd1);
        chk("rst_ifid_write", 32'(bus.ifid_write), 32'd1);
        chk("rst_ifid_flush", 32'(bus.ifid_flush), 32'd0);
        chk("rst_mc_busy",    32'(bus.mc_busy),    32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // lw x5 ; add x6,x5,x1 -> one stall, one bubble, then add issues
        drive(lw_c, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(add_c, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("lu_bubble_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        cycle();
        chk("lu_add_issued", 32'(bus.ex_ctrl), 32'(add_c));
        chk("lu_bubble_cnt", 32'(bus.bubble_cnt), 32'd1);

        // lw x0 then use x0: not a hazard
        drive(lw_c, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(add_c, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();

        // rs2 matches the load but is not read: not a hazard
        drive(lw_c, 5'd5, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(add_c, 5'd8, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("no_false_bubble_cnt", 32'(bus.bubble_cnt), 32'd1);

        // Multi-cycle op: three held cycles, EX unchanged, then next issue
        drive(mul_c, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(add_c, 5'd10, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (MC_LAT - 1) cycle();
        chk("mc_held_ex_ctrl", 32'(bus.ex_ctrl), 32'(mul_c));
        cycle();
        chk("mc_next_issue", 32'(bus.ex_ctrl), 32'(add_c));

        // Redirect colliding with a load-use hazard: single bubble
        drive(lw_c, 5'd5, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(add_c, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("redir_lu_bubble_cnt", 32'(bus.bubble_cnt), 32'd2);

        // Redirect during the multi-cycle hold
        drive(mul_c, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(add_c, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(add_c, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        drive(add_c, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("redir_mc_run", 32'(bus.ex_ctrl), 32'(add_c));

        // Reset in the middle of a multi-cycle hold
        drive(mul_c, 5'd14, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        #1;
        reset = 1'b1;
        #1;
        chk("mrst_ex_ctrl",    32'(bus.ex_ctrl),    32'd0);
        chk("mrst_ex_rd",      32'(bus.ex_rd),      32'd0);
        chk("mrst_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("mrst_pc_write",   32'(bus.pc_write),   32'd1);
        chk("mrst_mc_busy",    32'(bus.mc_busy),    32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(add_c, 5'd15, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();

        // Nine bubbles: the 3-bit counter must park at 7
        repeat (9) begin
            drive_rand();
            bus.ex_redirect = 1'b1;
            cycle();
        end
        chk("sat_bubble_cnt3", 32'(bus_s.bubble_cnt), 32'd7);
        chk("sat_bubble_cnt16", 32'(bus.bubble_cnt), 32'd9);

        repeat (400) begin
            drive_rand();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
